// File: rtl/apb4_mem_slave_pkg.sv
// rtl/apb4_mem_slave_pkg.sv - shared types and helpers for the APB4 memory slave
package apb4_mem_slave_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} apb_slv_state_e;

  localparam int APB_MAX_WAIT_CYC = 15;

  // Number of byte-offset bits below the word index.
  function automatic int apb_align(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb4_mem_slave_if.sv
// rtl/apb4_mem_slave_if.sv - APB4 bus bundle; pstrb present only with APB_STRB_EN
interface apb4_mem_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
`ifdef APB_STRB_EN
  logic [DATA_W/8-1:0] pstrb;
`endif
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

`ifdef APB_STRB_EN
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
`else
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
`endif

endinterface

// File: rtl/apb4_mem_slave_mem_array.sv
// rtl/apb4_mem_slave_mem_array.sv - DEPTH x DATA_W word store, byte-enabled write, async read
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Guard keeps a non-power-of-two DEPTH from reading past the array.
  assign rdata = (32'(raddr) < 32'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/apb4_mem_slave.sv
// rtl/apb4_mem_slave.sv - APB4 memory slave with wait states and error response; APB_STRB_EN adds pstrb
module apb4_mem_slave
  import apb4_mem_slave_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 0
) (
  input  logic             pclk,
  input  logic             preset,
  apb4_mem_slave_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int ALIGN = apb_align(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(APB_MAX_WAIT_CYC + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN) - 1);
  localparam logic [CNT_W-1:0]  WAIT_LD    = CNT_W'(WAIT_CYC);

  apb_slv_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lat_write_q;
  logic [IDX_W-1:0]  lat_idx_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic [NB-1:0]     lat_strb_q;
  logic              err_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;

  logic              load;
  logic              commit;
  logic              enter_done;
  logic              cur_err;
  logic              cur_write;
  logic [ADDR_W-1:0] word_idx;
  logic              setup_err;
  logic              strb_err;
  logic [NB-1:0]     strb_in;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign word_idx = bus.paddr >> ALIGN;

`ifdef APB_STRB_EN
  assign strb_in  = bus.pstrb;
  assign strb_err = !bus.pwrite && (bus.pstrb != '0);
`else
  assign strb_in  = '1;
  assign strb_err = 1'b0;
`endif

  assign setup_err = ((bus.paddr & ALIGN_MASK) != '0)
                   || (32'(word_idx) >= 32'(DEPTH))
                   || strb_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.psel && !bus.penable) begin
          load    = 1'b1;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYC == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.psel)             state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        else                       cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        commit  = bus.psel && bus.penable && lat_write_q && !err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With no wait states DONE is entered straight from the setup edge, so the
  // freshly decoded request must be used instead of the latched copy.
  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
  assign cur_err    = load ? setup_err : err_q;
  assign cur_write  = load ? bus.pwrite : lat_write_q;
  assign rd_idx     = load ? word_idx[IDX_W-1:0] : lat_idx_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_write_q <= 1'b0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      lat_strb_q  <= '0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= enter_done;
      pslverr_q <= enter_done && cur_err;
      if (load) begin
        lat_write_q <= bus.pwrite;
        lat_idx_q   <= word_idx[IDX_W-1:0];
        lat_wdata_q <= bus.pwdata;
        lat_strb_q  <= strb_in;
        err_q       <= setup_err;
      end
      if (enter_done && cur_err)        prdata_q <= '0;
      else if (enter_done && !cur_write) prdata_q <= mem_rdata;
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk    (pclk),
    .rst    (preset),
    .waddr  (lat_idx_q),
    .wdata  (lat_wdata_q),
    .wbe    (commit ? lat_strb_q : '0),
    .raddr  (rd_idx),
    .rdata  (mem_rdata)
  );

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule
